dac_seq: RTL and testbench

DAC_SEQ -- requirements
Module: dac_seq

---
 rtl/dac_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_dac_seq.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_seq.sv
// Circular word FIFO used to buffer DAC samples ahead of the sequencer.
// Latency: a push is visible on level/empty/full the cycle after its edge; pop_dat is combinational from the head.
// Backpressure: a push while full is accepted only if a pop happens in the same cycle, otherwise it is ignored.
module dac_seq_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_vld,
    output logic [W-1:0]             pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign pop_dat = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        push_ok  = push_vld && (!full || pop_vld);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_vld) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_vld})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end
endmodule

// DAC word sequencer: buffers words and hands them one at a time to Dac_ctrl with a one-cycle low ctrl strobe.
// Latency: a word written into an empty FIFO with the FSM idle is on dato with ctrl low three cycles later.
// Backpressure: writes while full (and not popping) are dropped and flagged on ovf; a stuck sync is flagged on tmo.
module dac_seq #(
    parameter int DEPTH   = 8,
    parameter int PERIOD  = 100,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [15:0]              wr_data,
    input  logic                     enable,
    input  logic                     sync,
    input  logic                     clr_err,
    output logic [15:0]              dato,
    output logic                     ctrl,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     ovf,
    output logic                     tmo
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        STROBE  = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4,
        HOLD    = 3'd5
    } state_t;

    localparam int PW = $clog2(PERIOD);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [PW-1:0] PER_MAX   = PW'(PERIOD - 1);
    // HOLD exit edge, IDLE and LOAD add three cycles before the next strobe,
    // so leaving HOLD at PERIOD-3 puts back-to-back strobes exactly PERIOD apart.
    localparam logic [PW-1:0] HOLD_EXIT = PW'(PERIOD - 3);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          ctrl_q, ctrl_d;
    logic [15:0]   dato_q, dato_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic          ovf_q, ovf_d;
    logic          tmo_q, tmo_d;
    logic          busy_q, busy_d;
    logic          pop_vld;
    logic [15:0]   pop_dat;
    logic          tmo_set;
    logic          drop;

    dac_seq_fifo #(
        .W     (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .push_vld (wr_en),
        .push_dat (wr_data),
        .pop_vld  (pop_vld),
        .pop_dat  (pop_dat),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    assign drop = wr_en && full && !pop_vld;
    assign dato = dato_q;
    assign ctrl = ctrl_q;
    assign busy = busy_q;
    assign ovf  = ovf_q;
    assign tmo  = tmo_q;

    // Next-state, strobe, counter and sticky-flag logic.
    always_comb begin
        state_d = state_q;
        ctrl_d  = 1'b1;
        dato_d  = dato_q;
        pop_vld = 1'b0;
        tmo_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pop_vld = 1'b1;
                dato_d  = pop_dat;
                ctrl_d  = 1'b0;
                state_d = STROBE;
            end
            STROBE: begin
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!sync) begin
                    state_d = WAIT_HI;
                end else if (wcnt_q >= TO_MAX) begin
                    tmo_set = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_HI: begin
                if (sync) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (pcnt_q >= HOLD_EXIT) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Both counters read 0 in the STROBE cycle and then age by one per cycle, saturating.
        if (state_q == LOAD) begin
            pcnt_d = '0;
            wcnt_d = '0;
        end else begin
            pcnt_d = (pcnt_q == PER_MAX) ? pcnt_q : pcnt_q + PW'(1);
            wcnt_d = (wcnt_q == TO_MAX)  ? wcnt_q : wcnt_q + TW'(1);
        end

        // A set event in the same cycle as clr_err keeps the flag raised.
        ovf_d  = drop    || (ovf_q && !clr_err);
        tmo_d  = tmo_set || (tmo_q && !clr_err);
        busy_d = (state_d != IDLE);
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctrl_q  <= 1'b1;
            dato_q  <= 16'h0000;
            pcnt_q  <= '0;
            wcnt_q  <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            dato_q  <= dato_d;
            pcnt_q  <= pcnt_d;
            wcnt_q  <= wcnt_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: tb/tb_dac_seq.sv
// Testbench for dac_seq: directed scenarios with random data and random sync behaviour.
// Expected strobe times come from arithmetic on write times and the strobe period.
// A responder process plays the role of Dac_ctrl on the sync line.
module tb_dac_seq;
    localparam int DEPTH   = 8;
    localparam int PERIOD  = 100;
    localparam int TIMEOUT = 64;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        enable;
    logic        sync;
    logic        clr_err;
    logic [15:0] dato;
    logic        ctrl;
    logic        full;
    logic        empty;
    logic [3:0]  level;
    logic        busy;
    logic        ovf;
    logic        tmo;

    dac_seq #(
        .DEPTH   (DEPTH),
        .PERIOD  (PERIOD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .enable  (enable),
        .sync    (sync),
        .clr_err (clr_err),
        .dato    (dato),
        .ctrl    (ctrl),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .busy    (busy),
        .ovf     (ovf),
        .tmo     (tmo)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          sq_t[$];
    logic [15:0] sq_d[$];
    logic [15:0] exp_q[$];
    bit          sync_auto = 1'b1;
    int          sync_lo   = 16;

    // Record every strobe cycle and the word presented with it.
    always @(negedge clk_in) begin
        if (rst_n === 1'b1 && ctrl === 1'b0) begin
            sq_t.push_back(cyc);
            sq_d.push_back(dato);
        end
    end

    // Dac_ctrl stand-in: two cycles after a strobe, pull sync low for sync_lo cycles (0 = random length).
    initial begin
        sync = 1'b1;
        forever begin
            @(negedge clk_in);
            if (sync_auto && rst_n === 1'b1 && ctrl === 1'b0) begin
                int len;
                len = (sync_lo == 0) ? int'($urandom_range(40, 1)) : sync_lo;
                repeat (2) @(posedge clk_in);
                #1 sync = 1'b0;
                repeat (len) @(posedge clk_in);
                #1 sync = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_in);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) nxt();
    endtask

    task automatic at(input int t);
        goto(t);
        @(negedge clk_in);
        #1;
    endtask

    task automatic write(input logic [15:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        nxt();
        wr_en   = 1'b0;
    endtask

    task automatic wait_strobes(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (sq_t.size() < n && k < budget) begin
            nxt();
            k++;
        end
        chk({tag, "_strobe_count"}, sq_t.size(), n);
    endtask

    task automatic check_strobe(input string tag, input int t_exp);
        int          t;
        logic [15:0] d;
        logic [15:0] e;
        if (sq_t.size() > 0) begin
            t = sq_t.pop_front();
            d = sq_d.pop_front();
            chk({tag, "_time"}, t, t_exp);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({tag, "_dato"}, d, e);
            end
        end else begin
            chk({tag, "_time_missing"}, -1, t_exp);
        end
    endtask

    initial begin
        int          c;
        int          s;
        int          e;
        int          n;
        int          prev;
        int          t;
        int          tq[$];
        logic [15:0] d;
        logic [15:0] w1;
        logic [15:0] w2;

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 16'h0000;
        enable  = 1'b0;
        clr_err = 1'b0;
        repeat (3) nxt();

        // Reset state
        at(cyc);
        chk("rst_ctrl",  ctrl,  1);
        chk("rst_dato",  dato,  0);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full",  full,  0);
        chk("rst_busy",  busy,  0);
        chk("rst_ovf",   ovf,   0);
        chk("rst_tmo",   tmo,   0);
        nxt();
        rst_n = 1'b1;
        nxt();
        nxt();

        // Single word: strobe three cycles after the write, busy until HOLD exit
        enable  = 1'b1;
        sync_lo = 16;
        c = cyc;
        write(16'hCAAA);
        exp_q.push_back(16'hCAAA);
        s = c + 3;
        at(s);
        chk("t1_ctrl_low", ctrl,  0);
        chk("t1_dato",     dato,  16'hCAAA);
        chk("t1_busy",     busy,  1);
        chk("t1_level",    level, 0);
        chk("t1_empty",    empty, 1);
        at(s + 1);
        chk("t1_ctrl_one_cycle", ctrl, 1);
        at(s + PERIOD - 3);
        chk("t1_busy_hold", busy, 1);
        at(s + PERIOD - 2);
        chk("t1_busy_done", busy, 0);
        wait_strobes("t1", 1, 5);
        check_strobe("t1", s);

        // Three back-to-back words: strobes exactly PERIOD apart
        goto(cyc + 5);
        c = cyc;
        for (int i = 1; i <= 3; i++) begin
            write(16'(i));
            exp_q.push_back(16'(i));
        end
        at(c + 3);
        chk("t2_level_a", level, 2);
        at(c + 3 + PERIOD);
        chk("t2_level_b", level, 1);
        wait_strobes("t2", 3, 400);
        for (int i = 0; i < 3; i++) check_strobe("t2", c + 3 + i * PERIOD);
        at(c + 3 + 2 * PERIOD + PERIOD - 2);
        chk("t2_empty", empty, 1);
        chk("t2_level", level, 0);
        chk("t2_busy",  busy,  0);

        // Overflow with enable low, clr_err, and set winning over clear
        enable = 1'b0;
        nxt();
        c = cyc;
        for (int i = 0; i < 8; i++) begin
            d = 16'($urandom);
            exp_q.push_back(d);
            write(d);
        end
        wr_en   = 1'b1;
        wr_data = 16'($urandom);
        at(c + 8);
        chk("t3_full",      full,  1);
        chk("t3_level8",    level, 8);
        chk("t3_ovf_pre",   ovf,   0);
        nxt();
        wr_en   = 1'b0;
        clr_err = 1'b1;
        at(c + 9);
        chk("t3_ovf_set",   ovf,   1);
        chk("t3_level_drop", level, 8);
        nxt();
        clr_err = 1'b0;
        at(c + 10);
        chk("t3_ovf_clr",   ovf,   0);
        nxt();
        wr_en   = 1'b1;
        clr_err = 1'b1;
        wr_data = 16'($urandom);
        nxt();
        wr_en   = 1'b0;
        clr_err = 1'b0;
        at(c + 12);
        chk("t3_set_wins",  ovf,   1);
        chk("t3_level_kept", level, 8);
        nxt();
        clr_err = 1'b1;
        nxt();
        clr_err = 1'b0;
        at(c + 14);
        chk("t3_ovf_clr2",  ovf,   0);
        chk("t3_no_strobe", sq_t.size(), 0);

        // Push while full in the LOAD cycle is accepted; then drain all nine
        nxt();
        e = cyc;
        enable = 1'b1;
        nxt();
        d = 16'($urandom);
        exp_q.push_back(d);
        write(d);
        at(e + 2);
        chk("t5_level8",  level, 8);
        chk("t5_full",    full,  1);
        chk("t5_ovf",     ovf,   0);
        chk("t5_ctrl",    ctrl,  0);
        wait_strobes("t5", 9, 1000);
        for (int i = 0; i < 9; i++) check_strobe("t5", e + 2 + i * PERIOD);
        at(e + 2 + 8 * PERIOD + PERIOD - 2);
        chk("t5_empty", empty, 1);
        chk("t5_level", level, 0);
        chk("t5_busy",  busy,  0);

        // sync stuck high: timeout, dato kept, next word strobed afterwards
        sync_auto = 1'b0;
        nxt();
        c  = cyc;
        w1 = 16'($urandom);
        w2 = 16'($urandom);
        write(w1);
        write(w2);
        exp_q.push_back(w1);
        exp_q.push_back(w2);
        s = c + 3;
        at(s + TIMEOUT - 1);
        chk("t4_tmo_pre",  tmo,  0);
        chk("t4_busy_pre", busy, 1);
        at(s + TIMEOUT);
        chk("t4_tmo",      tmo,  1);
        chk("t4_idle",     busy, 0);
        chk("t4_dato_kept", dato, w1);
        nxt();
        sync_auto = 1'b1;
        at(s + TIMEOUT + 1);
        chk("t4_dato_load", dato, w1);
        wait_strobes("t4", 2, 20);
        check_strobe("t4a", s);
        check_strobe("t4b", s + TIMEOUT + 2);
        nxt();
        clr_err = 1'b1;
        nxt();
        clr_err = 1'b0;
        at(cyc);
        chk("t4_tmo_clr", tmo, 0);
        at(s + TIMEOUT + 2 + PERIOD - 2);
        chk("t4_busy_done", busy, 0);

        // Random rounds: strobe at max(previous strobe + PERIOD, write + 3)
        sync_lo = 0;
        for (int r = 0; r < 3; r++) begin
            nxt();
            n    = int'($urandom_range(4, 1));
            prev = -10 * PERIOD;
            tq.delete();
            for (int i = 0; i < n; i++) begin
                repeat (int'($urandom_range(150, 0))) nxt();
                c = cyc;
                d = 16'($urandom);
                exp_q.push_back(d);
                write(d);
                t = (prev + PERIOD > c + 3) ? prev + PERIOD : c + 3;
                tq.push_back(t);
                prev = t;
            end
            wait_strobes("rnd", n, 700);
            for (int i = 0; i < n; i++) check_strobe("rnd", tq[i]);
            at(prev + PERIOD - 2);
            chk("rnd_busy",  busy,  0);
            chk("rnd_empty", empty, 1);
        end

        // Reset during WAIT_HI with four words still queued
        sync_lo = 16;
        nxt();
        c = cyc;
        for (int i = 0; i < 5; i++) begin
            d = 16'($urandom);
            exp_q.push_back(d);
            write(d);
        end
        s = c + 3;
        at(s + 9);
        chk("t6_level4", level, 4);
        check_strobe("t6", s);
        at(s + 10);
        rst_n = 1'b0;
        #1;
        chk("t6_ctrl",  ctrl,  1);
        chk("t6_dato",  dato,  0);
        chk("t6_level", level, 0);
        chk("t6_empty", empty, 1);
        chk("t6_full",  full,  0);
        chk("t6_busy",  busy,  0);
        nxt();
        nxt();
        rst_n = 1'b1;
        exp_q.delete();
        repeat (300) nxt();
        chk("t6_no_strobe", sq_t.size(), 0);
        c = cyc;
        d = 16'($urandom);
        exp_q.push_back(d);
        write(d);
        wait_strobes("t6_new", 1, 10);
        check_strobe("t6_new", c + 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
